// File: rtl/qspi_pkg.sv
// Shared definitions for the quad-SPI host: FSM states, phase lengths and
// opcodes understood by the bridge's QSPI target.
package qspi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StDesel
  } qspi_state_e;

  localparam int unsigned CMD_NIB  = 2;
  localparam int unsigned CMD_BITS = 8;
  localparam int unsigned ADDR_NIB = 8;
  localparam int unsigned WORD_NIB = 4;

  localparam logic [7:0] OP_READ   = 8'h0B;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h05;

endpackage

// File: rtl/qspi_sck_gen.sv
// SCK divider: toggles sck every CLK_DIV cycles while enabled and flags the
// cycle in which each rising/falling edge will be taken.
module qspi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       tick;

  // Strobes are asserted in the cycle before sck actually changes.
  always_comb begin
    tick   = en_i && (cnt_q == 8'(CLK_DIV - 1));
    rise_o = tick && !sck_q;
    fall_o = tick && sck_q;
    cnt_d  = cnt_q + 8'd1;
    sck_d  = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end
  end

  // Divider state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/qspi_host.sv
// Quad-SPI initiator: command, 32-bit address, optional dummy cycles and
// len_i 16-bit words on a 4-bit bus. Define QSPI_HOST_CMD_1BIT_EN to send the
// command serially on io[0] instead of as two quad nibbles.
module qspi_host
  import qspi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_HIGH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  cmd_i,
  input  logic [31:0] addr_i,
  input  logic        dir_i,
  input  logic [4:0]  dummy_i,
  input  logic [7:0]  len_i,
  input  logic [15:0] wdata_i,
  output logic        wdata_ack_o,
  output logic [15:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        qspi_sck,
  output logic        qspi_sce,
  output logic [3:0]  qspi_io_o,
  input  logic [3:0]  qspi_io_i,
  output logic        qspi_io_oe
);

`ifdef QSPI_HOST_CMD_1BIT_EN
  localparam int unsigned CmdCycles = CMD_BITS;
  localparam int unsigned CmdShift  = 1;
`else
  localparam int unsigned CmdCycles = CMD_NIB;
  localparam int unsigned CmdShift  = 4;
`endif

  qspi_state_e state_q, state_d;
  logic [31:0] sh_q, sh_d, addr_q, addr_d;
  logic [4:0]  nib_q, nib_d, dummy_q, dummy_d;
  logic [7:0]  word_q, word_d, len_q, len_d, cs_q, cs_d;
  logic [11:0] rsh_q, rsh_d;
  logic [15:0] rdata_q, rdata_d;
  logic        dir_q, dir_d, rvalid_q, rvalid_d, done_q, done_d, ack_q, ack_d;
  logic        active, rise, fall, load_word;

  assign active = (state_q == StCmd) || (state_q == StAddr) ||
                  (state_q == StDummy) || (state_q == StData);

  qspi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (active),
    .sck_o  (qspi_sck),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Next-state logic: phases advance on SCK falling edges, reads sample on rising edges.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    nib_d     = nib_q;
    dummy_d   = dummy_q;
    word_d    = word_q;
    len_d     = len_q;
    cs_d      = cs_q;
    rsh_d     = rsh_q;
    rdata_d   = rdata_q;
    dir_d     = dir_q;
    rvalid_d  = 1'b0;
    done_d    = 1'b0;
    ack_d     = 1'b0;
    load_word = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sh_d    = {cmd_i, 24'h0};
          addr_d  = addr_i;
          dir_d   = dir_i;
          dummy_d = dummy_i;
          len_d   = len_i;
          nib_d   = '0;
          word_d  = '0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (fall) begin
          sh_d  = sh_q << CmdShift;
          nib_d = nib_q + 5'd1;
          if (nib_q == 5'(CmdCycles - 1)) begin
            sh_d    = addr_q;
            nib_d   = '0;
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (fall) begin
          sh_d  = sh_q << 4;
          nib_d = nib_q + 5'd1;
          if (nib_q == 5'(ADDR_NIB - 1)) begin
            nib_d = '0;
            if (dummy_q != 5'd0) begin
              state_d = StDummy;
            end else if (len_q != 8'd0) begin
              state_d   = StData;
              load_word = 1'b1;
            end else begin
              state_d = StDesel;
            end
          end
        end
      end
      StDummy: begin
        if (fall) begin
          nib_d = nib_q + 5'd1;
          if (nib_q == dummy_q - 5'd1) begin
            nib_d = '0;
            if (len_q != 8'd0) begin
              state_d   = StData;
              load_word = 1'b1;
            end else begin
              state_d = StDesel;
            end
          end
        end
      end
      StData: begin
        if (rise && dir_q) begin
          rsh_d = {rsh_q[7:0], qspi_io_i};
          if (nib_q == 5'(WORD_NIB - 1)) begin
            rdata_d  = {rsh_q, qspi_io_i};
            rvalid_d = 1'b1;
          end
        end
        if (fall) begin
          sh_d  = sh_q << 4;
          nib_d = nib_q + 5'd1;
          if (nib_q == 5'(WORD_NIB - 1)) begin
            nib_d = '0;
            if (word_q == len_q - 8'd1) begin
              state_d = StDesel;
            end else begin
              word_d    = word_q + 8'd1;
              load_word = 1'b1;
            end
          end
        end
      end
      StDesel: begin
        cs_d = cs_q + 8'd1;
        if (cs_q == 8'(CS_HIGH - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load_word && !dir_q) begin
      sh_d  = {wdata_i, 16'h0};
      ack_d = 1'b1;
    end
    if ((state_d == StDesel) && (state_q != StDesel)) begin
      cs_d   = '0;
      done_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any transfer without done_o.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      sh_q     <= '0;
      addr_q   <= '0;
      nib_q    <= '0;
      dummy_q  <= '0;
      word_q   <= '0;
      len_q    <= '0;
      cs_q     <= '0;
      rsh_q    <= '0;
      rdata_q  <= '0;
      dir_q    <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      addr_q   <= addr_d;
      nib_q    <= nib_d;
      dummy_q  <= dummy_d;
      word_q   <= word_d;
      len_q    <= len_d;
      cs_q     <= cs_d;
      rsh_q    <= rsh_d;
      rdata_q  <= rdata_d;
      dir_q    <= dir_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
    end
  end

  // Bus outputs decoded from the registered phase; reads release io after the address.
  always_comb begin
    qspi_io_o = 4'h0;
    unique case (state_q)
`ifdef QSPI_HOST_CMD_1BIT_EN
      StCmd:   qspi_io_o = {3'b000, sh_q[31]};
`else
      StCmd:   qspi_io_o = sh_q[31:28];
`endif
      StAddr:  qspi_io_o = sh_q[31:28];
      StData:  qspi_io_o = dir_q ? 4'h0 : sh_q[31:28];
      default: qspi_io_o = 4'h0;
    endcase
  end

  assign qspi_sce      = !active;
  assign qspi_io_oe    = (state_q == StCmd) || (state_q == StAddr) || (active && !dir_q);
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign wdata_ack_o   = ack_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;

endmodule

// File: tb/tb_qspi_host.sv
// Directed self-checking bench for qspi_host with a small QSPI target model.
module tb_qspi_host;

`ifdef QSPI_HOST_CMD_1BIT_EN
  localparam int CmdP = 8;
`else
  localparam int CmdP = 2;
`endif
  localparam int CLK_DIV = 2;
  localparam int CS_HIGH = 4;
  localparam int Budget  = 3000;

  logic        clk, reset_i, start_i, dir_i;
  logic [7:0]  cmd_i, len_i;
  logic [31:0] addr_i;
  logic [4:0]  dummy_i;
  logic [15:0] wdata_i, rdata_o;
  logic        wdata_ack_o, rdata_valid_o, busy_o, done_o;
  logic        qspi_sck, qspi_sce, qspi_io_oe;
  logic [3:0]  qspi_io_o, qspi_io_i;

  qspi_host #(
    .CLK_DIV(CLK_DIV),
    .CS_HIGH(CS_HIGH)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .cmd_i        (cmd_i),
    .addr_i       (addr_i),
    .dir_i        (dir_i),
    .dummy_i      (dummy_i),
    .len_i        (len_i),
    .wdata_i      (wdata_i),
    .wdata_ack_o  (wdata_ack_o),
    .rdata_o      (rdata_o),
    .rdata_valid_o(rdata_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .qspi_sck     (qspi_sck),
    .qspi_sce     (qspi_sce),
    .qspi_io_o    (qspi_io_o),
    .qspi_io_i    (qspi_io_i),
    .qspi_io_oe   (qspi_io_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int rises, low_cyc, nlog, acks, valids, dones, wq_idx;
  logic       sce_prev, sck_prev;
  logic [3:0] log_io [64];
  logic       log_oe [64];
  logic [15:0] last_rd, rd_word;
  logic       rd_mode;
  int         rd_dummy;
  logic [15:0] wq [4] = '{16'hA5C3, 16'h1234, 16'h0000, 16'h0000};
  logic [3:0]  exp_wr [18] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                               4'h0, 4'hA, 4'h5, 4'hC, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    rises = 0; low_cyc = 0; nlog = 0; acks = 0; valids = 0; dones = 0;
    wq_idx = 0; wdata_i = wq[0];
  endtask

  // One clk_i cycle: sample on the falling edge, log bus activity, act as the target.
  task automatic step();
    int idx;
    @(negedge clk);
    if (!qspi_sce && sce_prev) begin
      rises = 0; low_cyc = 0; nlog = 0;
    end
    if (qspi_sck && !sck_prev) begin
      if (nlog < 64) begin
        log_io[nlog] = qspi_io_o;
        log_oe[nlog] = qspi_io_oe;
      end
      nlog++;
      rises++;
    end
    if (!qspi_sce) low_cyc++;
    if (wdata_ack_o) begin
      acks++;
      wq_idx++;
      wdata_i = wq[wq_idx & 3];
    end
    if (rdata_valid_o) begin
      valids++;
      last_rd = rdata_o;
    end
    if (done_o) dones++;
    idx = rises - CmdP - 8 - rd_dummy;
    if (rd_mode && idx >= 0 && idx < 4) qspi_io_i = rd_word[15 - 4*idx -: 4];
    else qspi_io_i = 4'h0;
    sce_prev = qspi_sce;
    sck_prev = qspi_sck;
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [31:0] addr, input logic dir,
                         input logic [4:0] dummy, input logic [7:0] len,
                         input logic [15:0] rword, input int pulse_at);
    int n;
    clear_counts();
    rd_mode = dir; rd_dummy = int'(dummy); rd_word = rword;
    cmd_i = cmd; addr_i = addr; dir_i = dir; dummy_i = dummy; len_i = len;
    start_i = 1'b1;
    step();
    n = 0;
    while (busy_o && n < Budget) begin
      start_i = (n == pulse_at);
      step();
      n++;
    end
    start_i = 1'b0;
    if (n >= Budget) check("txn_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n, gap, lows;
    reset_i = 1'b1; start_i = 1'b0; cmd_i = '0; addr_i = '0; dir_i = 1'b0;
    dummy_i = '0; len_i = '0; qspi_io_i = '0; rd_mode = 1'b0; rd_dummy = 0;
    rd_word = '0; last_rd = '0; sce_prev = 1'b1; sck_prev = 1'b0;
    clear_counts();
    repeat (3) step();
    check("rst_sce", 32'(qspi_sce), 32'd1);
    check("rst_sck", 32'(qspi_sck), 32'd0);
    check("rst_oe", 32'(qspi_io_oe), 32'd0);
    check("rst_io", 32'(qspi_io_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ack", 32'(wdata_ack_o), 32'd0);
    check("rst_valid", 32'(rdata_valid_o), 32'd0);
    check("rst_rdata", 32'(rdata_o), 32'd0);
    reset_i = 1'b0;
    repeat (2) step();

    // Write: two words.
    run_txn(8'h02, 32'h0001_2340, 1'b0, 5'd0, 8'd2, 16'h0, -1);
    for (int i = ((CmdP == 2) ? 0 : 2); i < 18; i++)
      check($sformatf("wr_nib%0d", i), 32'(log_io[i + CmdP - 2]), 32'(exp_wr[i]));
    check("wr_periods", rises, CmdP + 16);
    check("wr_low_cyc", low_cyc, (CmdP + 16) * 2 * CLK_DIV);
    check("wr_acks", acks, 2);
    check("wr_dones", dones, 1);
    check("wr_oe_last", 32'(log_oe[CmdP + 15]), 32'd1);

    // Read with 6 dummy cycles.
    run_txn(8'h0B, 32'h0000_0100, 1'b1, 5'd6, 8'd1, 16'hBEEF, -1);
    check("rd_data", 32'(last_rd), 32'hBEEF);
    check("rd_valids", valids, 1);
    check("rd_periods", rises, CmdP + 8 + 6 + 4);
    check("rd_oe_addr", 32'(log_oe[CmdP + 7]), 32'd1);
    check("rd_oe_dummy", 32'(log_oe[CmdP + 8]), 32'd0);
    check("rd_acks", acks, 0);
    check("rd_dones", dones, 1);

    // Read with no dummy cycles.
    run_txn(8'h0B, 32'h0000_0200, 1'b1, 5'd0, 8'd1, 16'h5A69, -1);
    check("rd0_data", 32'(last_rd), 32'h5A69);
    check("rd0_oe_data", 32'(log_oe[CmdP + 8]), 32'd0);

    // Zero length, zero dummy, with a stray start pulse mid-transfer.
    run_txn(8'h05, 32'hFFFF_FFFF, 1'b0, 5'd0, 8'd0, 16'h0, 15);
    check("z_periods", rises, CmdP + 8);
    check("z_low_cyc", low_cyc, (CmdP + 8) * 2 * CLK_DIV);
    check("z_acks", acks, 0);
    check("z_valids", valids, 0);
    check("z_dones", dones, 1);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!qspi_sce) lows++;
    end
    check("z_idle_after", lows, 0);

    // Back-to-back: start held high.
    clear_counts();
    rd_mode = 1'b0; rd_dummy = 0;
    cmd_i = 8'h02; addr_i = 32'h0; dir_i = 1'b0; dummy_i = 5'd0; len_i = 8'd0;
    start_i = 1'b1;
    n = 0;
    while (!done_o && n < 500) begin step(); n++; end
    gap = 0;
    while (qspi_sce && n < 500) begin gap++; step(); n++; end
    check("b2b_bound", 32'(n < 500), 32'd1);
    check("b2b_gap", 32'(gap >= CS_HIGH), 32'd1);
    check("b2b_dones1", dones, 1);
    start_i = 1'b0;
    n = 0;
    while (busy_o && n < 500) begin step(); n++; end
    check("b2b_dones2", dones, 2);

    // Reset during the address phase.
    clear_counts();
    cmd_i = 8'h02; addr_i = 32'h0001_2340; dir_i = 1'b0; dummy_i = 5'd0; len_i = 8'd2;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while (rises < 5 && n < 500) begin step(); n++; end
    reset_i = 1'b1;
    step();
    check("ra_sce", 32'(qspi_sce), 32'd1);
    check("ra_sck", 32'(qspi_sck), 32'd0);
    check("ra_oe", 32'(qspi_io_oe), 32'd0);
    check("ra_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    repeat (8) step();
    check("ra_nodone", dones, 0);
    run_txn(8'h02, 32'h0001_2340, 1'b0, 5'd0, 8'd2, 16'h0, -1);
    check("ra_redo_dones", dones, 1);
    check("ra_redo_periods", rises, CmdP + 16);
    check("ra_redo_nib", 32'(log_io[CmdP + 8]), 32'hA);

`ifdef QSPI_HOST_CMD_1BIT_EN
    // Serial command 0x9F on io[0].
    run_txn(8'h9F, 32'h1234_5678, 1'b0, 5'd0, 8'd0, 16'h0, -1);
    for (int i = 0; i < 8; i++)
      check($sformatf("c1_bit%0d", i), 32'(log_io[i]), 32'((8'h9F >> (7 - i)) & 8'h1));
    check("c1_addr0", 32'(log_io[8]), 32'h1);
    check("c1_addr1", 32'(log_io[9]), 32'h2);
    check("c1_periods", rises, 16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qspi_host.md
Name: qspi_host

Overview:
- Synthesizable quad-SPI initiator: the host end of the bridge's QSPI target interface.
- Serialises one transaction as command, 32-bit address, optional dummy cycles, then N 16-bit data words (write or read) on qspi_io.
- Used on the bench-side FPGA and in system sims to drive the bridge's QSPI port directly.
- Controlled by a simple start/busy/done interface from a local sequencer.

Parameters:
- CLK_DIV, 2: SCK half-period in clk_i cycles; legal range ≥1.
- CS_HIGH, 4: minimum clk_i cycles qspi_sce stays high between transactions.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  launch a transaction; sampled only in IDLE.
- cmd_i  in  8  command opcode.
- addr_i  in  32  address.
- dir_i  in  1  1 = read, 0 = write.
- dummy_i  in  5  dummy SCK cycles, 0–31.
- len_i  in  8  data words, 0–255; 0 means no data phase.
- wdata_i  in  16  write word; must be valid when wdata_ack_o pulses.
- wdata_ack_o  out  1  1-cycle pulse: wdata_i consumed; the next word is due within 4 SCK periods.
- rdata_o  out  16  last received word.
- rdata_valid_o  out  1  1-cycle pulse: rdata_o updated.
- busy_o  out  1  high from start accept until CS_HIGH completes.
- done_o  out  1  1-cycle pulse when qspi_sce deasserts.
- qspi_sck  out  1  serial clock, mode 0.
- qspi_sce  out  1  chip enable, active-low.
- qspi_io_o  out  4  data out, MSB nibble first.
- qspi_io_i  in  4  data in.
- qspi_io_oe  out  1  output enable for qspi_io_o.

Behaviour:
- Reset values:
  - qspi_sce = 1, qspi_sck = 0, qspi_io_oe = 0, qspi_io_o = 0.
  - busy_o, done_o, wdata_ack_o, rdata_valid_o = 0; rdata_o = 0.
  - State = IDLE.
  - Reset mid-transfer aborts on the next clk_i edge: sce goes high, sck goes low, and done_o is not pulsed.
- States: IDLE → CMD (2 nibbles) → ADDR (8) → DUMMY (dummy_i SCK cycles; skipped if 0) → DATA (4 nibbles per word × len_i; skipped if 0) → DESEL (CS_HIGH cycles) → IDLE.
- Start:
  - start_i in IDLE latches cmd/addr/dir/dummy/len.
  - Next cycle: sce goes low, busy_o goes high, and the first command nibble is driven with oe = 1.
  - start_i while busy is ignored.
- SCK timing:
  - qspi_sck_gen emits rise/fall strobes every CLK_DIV cycles once the phase is active.
  - First rising edge occurs CLK_DIV cycles after sce falls.
  - Host shifts the next nibble on each falling edge and samples qspi_io_i on each rising edge.
  - SCK period = 2·CLK_DIV clk_i cycles; sck returns low before sce rises.
- Write data:
  - At each word load (DATA entry, and after every 4th fall), wdata_i is captured into the shift register and wdata_ack_o pulses in the same cycle.
  - The 16-bit shift register sends bits [15:12] first.
- Read data:
  - qspi_io_oe drops on the falling edge that ends ADDR; the dummy cycles give the turnaround.
  - If dummy_i = 0 on a read, oe drops at the same point and sampling starts on the next rise.
  - After the 4th rising-edge sample of a word, rdata_o updates and rdata_valid_o pulses the next cycle.
- End of transfer: after the last nibble's falling edge, sce rises, oe goes 0, done_o pulses, and busy_o stays high through CS_HIGH.
- Total duration, sce-low span in SCK periods: 10 + dummy + 4·len (command phase as above).

Optional Feature:
- Macro: QSPI_HOST_CMD_1BIT_EN.
- Defined: CMD phase is 8 SCK cycles on qspi_io_o[0] only, MSB first; io_o[3:1] = 0 with oe still 1. Address and data remain quad.
- Undefined: command is sent as 2 quad nibbles.

Decomposition:
- Package qspi_pkg:
  - State enum.
  - Phase nibble counts: CMD_NIB = 2, ADDR_NIB = 8, WORD_NIB = 4.
  - Opcode constants shared with the bridge target: read, write, status.
- Sub-module qspi_sck_gen: divider counter producing sck, rise strobe and fall strobe; enabled only outside IDLE/DESEL.

Test Plan:
- Write: cmd = 0x02, addr = 0x0001_2340, len = 2, wdata 0xA5C3 then 0x1234, CLK_DIV = 2 → io nibbles 0,2,0,0,0,1,2,3,4,0,A,5,C,3,1,2,3,4; 18 SCK periods; two wdata_ack_o pulses; done_o once.
- Read: cmd = 0x0B, dummy = 6, len = 1, target drives 0xBEEF → oe low from dummy start; rdata_o = 0xBEEF with one rdata_valid_o pulse; sce low for 20 SCK periods.
- Zero-length/zero-dummy: len = 0, dummy = 0 → only 10 SCK periods; no ack/valid pulses; done_o pulses.
- Back-to-back: start_i held high with busy → second transaction begins only after CS_HIGH sce-high cycles; start_i pulsed mid-transfer has no effect.
- Reset asserted during ADDR → next cycle sce = 1, sck = 0, oe = 0, busy_o = 0, no done_o; a fresh start then completes normally.
- With QSPI_HOST_CMD_1BIT_EN, cmd = 0x9F → io[0] serial 1,0,0,1,1,1,1,1 over 8 SCK periods, then quad address.
